// File: rtl/base_emux_arb_pkg.sv
// ============================================================
// base_emux_arb_pkg : shared helpers for round-robin blocks
// Rev 1.0
// ============================================================
`default_nettype none

package base_emux_arb_pkg;

    // Next index in a cyclic sequence of n entries; wraps at n, not at a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/base_decode.sv
// ============================================================
// base_decode : binary index to one-hot with enable
// Rev 1.0
// ============================================================
`default_nettype none

module base_decode #(
    parameter int n = 4,
    parameter int w = 2
) (
    input  logic         en,
    input  logic [0:w-1] idx,
    output logic [0:n-1] dec
);

    for (genvar k = 0; k < n; k++) begin : g_dec
        assign dec[k] = en && (idx == w'(k));
    end

endmodule

`default_nettype wire

// File: rtl/base_rr_pick.sv
// ============================================================
// base_rr_pick : combinational cyclic priority encoder
// Rev 1.0
// ============================================================
`default_nettype none

module base_rr_pick #(
    parameter int ways      = 4,
    parameter int sel_width = $clog2(ways)
) (
    input  logic [0:ways-1]      elig,
    input  logic [0:sel_width-1] ptr,
    output logic                 any,
    output logic [0:sel_width-1] idx
);

    logic                 hi_any;
    logic [0:sel_width-1] hi_idx;
    logic                 lo_any;
    logic [0:sel_width-1] lo_idx;

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = ways - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_any = 1'b1;
                lo_idx = sel_width'(i);
                if (i >= int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = sel_width'(i);
                end
            end
        end
    end

    assign any = lo_any;
    assign idx = hi_any ? hi_idx : lo_idx;

endmodule

`default_nettype wire

// File: rtl/base_emux_arb.sv
// ============================================================
// base_emux_arb : round-robin arbiter driving an encoded mux select
// Rev 1.0
// ============================================================
`default_nettype none

module base_emux_arb
    import base_emux_arb_pkg::*;
#(
    parameter int ways      = 4,
    parameter int sel_width = $clog2(ways)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:ways-1]      i_v,
    output logic [0:ways-1]      i_r,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [0:sel_width-1] o_sel,
    output logic [0:ways-1]      o_sel_dec
);

    logic                 done;
    logic                 ld;
    logic [0:ways-1]      elig;
    logic [0:sel_width-1] ptr;
    logic                 pick_any;
    logic [0:sel_width-1] pick_idx;
    logic                 v_nxt;
    logic [0:sel_width-1] sel_nxt;
    logic [0:sel_width-1] ptr_nxt;

    assign done = o_v & o_r;
    assign ld   = ~o_v | done;

    // The retiring way's i_v still describes the item just accepted, so it cannot win again now.
    always_comb begin
        elig = i_v;
        if (done) begin
            elig[o_sel] = 1'b0;
        end
    end

    always_comb begin
        i_r = '0;
        if (done) begin
            i_r[o_sel] = 1'b1;
        end
    end

    base_rr_pick #(
        .ways      (ways),
        .sel_width (sel_width)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        v_nxt   = o_v;
        sel_nxt = o_sel;
        ptr_nxt = ptr;
        if (ld) begin
            v_nxt = pick_any;
            if (pick_any) begin
                sel_nxt = pick_idx;
                ptr_nxt = sel_width'(rr_next(int'(pick_idx), ways));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_v   <= 1'b0;
            o_sel <= '0;
            ptr   <= '0;
        end else begin
            o_v   <= v_nxt;
            o_sel <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

    base_decode #(
        .n (ways),
        .w (sel_width)
    ) u_dec (
        .en  (o_v),
        .idx (o_sel),
        .dec (o_sel_dec)
    );

endmodule

`default_nettype wire
